nibble_swap_arbiter: RTL
========================

// Module: nibble_swap_arbiter
//
// PURPOSE
//   Shares one nibble-swap datapath between NUM_REQ requesters.
//   - Round-robin arbitration; at most one byte accepted per cycle.
//   - Each accepted byte is optionally nibble-swapped, registered, and presented on a single
//     valid/ready output port tagged with the requester ID.
//   - Sits between per-channel byte sources and the shared downstream byte sink.
//
// PARAMETERS
//   NUM_REQ  4   number of requesters, >= 1
//   ID_W     2   width of out_id, = max(1, $clog2(NUM_REQ))
//   CNT_W    16  width of the xfer_cnt transaction counter
//
// PORTS
//   clk        in   1          single clock, rising edge
//   rst_n      in   1          asynchronous reset, active-low
//   req_valid  in   NUM_REQ    per-requester byte valid
//   req_data   in   8*NUM_REQ  byte for requester i is req_data[8*i+7:8*i]
//   req_swap   in   NUM_REQ    1 = swap nibbles of this byte, 0 = pass through
//   req_ready  out  NUM_REQ    one-hot grant; byte i is taken when req_valid[i] & req_ready[i]
//   out_valid  out  1          output byte valid
//   out_data   out  8          processed byte
//   out_id     out  ID_W       index of the requester that supplied out_data
//   out_ready  in   1          downstream accepts out_data this cycle
//   xfer_cnt   out  CNT_W      count of accepted bytes, wraps modulo 2^CNT_W
//
// BEHAVIOUR
//   - Reset values: out_valid=0, out_data=0, out_id=0, xfer_cnt=0, rr_ptr=0.
//     req_ready is all-zero while rst_n=0.
//   - Reset asserted mid-operation discards any held output byte.
//   - slot_free = !out_valid | out_ready.
//   - accept = slot_free & |req_valid.
//   - Grant selection:
//     - The grant is the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ...
//       and wrapping modulo NUM_REQ.
//     - req_ready = accept ? onehot(grant) : 0.
//     - req_ready is combinational from req_valid, out_valid and out_ready. Requesters must
//       not make req_valid depend on req_ready.
//   - On accept (registered, latency 1 cycle):
//     - out_data <= req_swap[g] ? {d[3:0], d[7:4]} : d, where d = byte of granted requester g.
//     - out_id <= g; out_valid <= 1.
//     - rr_ptr <= (g == NUM_REQ-1) ? 0 : g+1.
//     - xfer_cnt <= xfer_cnt+1, wrapping to 0 at 2^CNT_W-1.
//   - No accept, out_valid & out_ready: out_valid <= 0; out_data and out_id hold their values.
//   - Stall (out_valid & !out_ready): out_valid, out_data and out_id are held stable;
//     req_ready=0; rr_ptr holds.
//   - Simultaneous drain and accept (out_valid & out_ready & accept): the new byte replaces
//     the old one with no bubble, giving full 1 byte/cycle throughput.
//   - No requester valid: rr_ptr holds; no grant is issued.
//   - req_valid dropped before grant is legal; no state is kept for a dropped request.
//   - NUM_REQ=1: rr_ptr is constantly 0 and out_id=0.
//
// STRUCTURE
//   - Package nibble_swap_pkg: NIBBLE_W=4, BYTE_W=8, function swap_nibbles(byte, en).
//   - Sub-module rr_arbiter #(N): inputs req, ptr, en; outputs one-hot grant and binary
//     grant index. It holds no state; rr_ptr lives in the parent.
//   - Parent holds rr_ptr, the output register, and xfer_cnt.
//
// TESTING
//   1. Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, xfer_cnt=0 and
//      req_ready=0 immediately (async); after release, first grant goes to the lowest valid.
//   2. Single requester: req_valid=4'b0100, data=8'hA5, swap=1, out_ready=1
//      -> next cycle out_data=8'h5A, out_id=2.
//      Same request with swap=0 -> out_data=8'hA5.
//   3. Round robin: all four req_valid held 1, out_ready=1
//      -> out_id sequence 0,1,2,3,0,... one per cycle; xfer_cnt increments by 1 each cycle.
//   4. Backpressure: hold out_ready=0 for 3 cycles with a byte pending
//      -> out_data/out_id stable and req_ready=0 throughout; on release, the next grant
//         issues the same cycle.
//   5. Wrap: rr_ptr=3 with req_valid=4'b1001 -> grant 3, then grant 0.
//      Preload xfer_cnt to 16'hFFFF, accept one byte -> xfer_cnt=16'h0000.

Source files
------------

// File: rtl/nibble_swap_arbiter_pkg.sv
// Shared definitions for the nibble-swap arbiter slice.
//   NIBBLE_W / BYTE_W : datapath widths
//   swap_nibbles()    : exchanges the two nibbles of a byte when en=1, else passes it through
package nibble_swap_pkg;

    localparam int NIBBLE_W = 4;
    localparam int BYTE_W   = 8;

    function automatic logic [BYTE_W-1:0] swap_nibbles(input logic [BYTE_W-1:0] b,
                                                       input logic              en);
        return en ? {b[NIBBLE_W-1:0], b[BYTE_W-1:NIBBLE_W]} : b;
    endfunction

endpackage

// File: rtl/nibble_swap_arbiter_rr.sv
// Stateless round-robin grant selection.
//   req       : request vector
//   ptr       : index where the search starts (wraps modulo N)
//   en        : when 0 the one-hot grant is forced to zero (index is still computed)
//   grant     : one-hot grant
//   grant_idx : binary index of the selected requester (0 when none is requesting)
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic found;

    always_comb begin : sel
        int unsigned idx;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant_idx  = IW'(idx);
                grant[idx] = en;
            end
        end
    end

endmodule

// File: rtl/nibble_swap_arbiter.sv
// Shares one nibble-swap datapath between NUM_REQ byte sources.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   req_valid  : per-requester byte valid
//   req_data   : packed bytes, requester i at [8*i+7:8*i]
//   req_swap   : per-requester nibble-swap enable
//   req_ready  : one-hot grant, combinational
//   out_valid, out_data, out_id, out_ready : registered valid/ready output port
//   xfer_cnt   : count of accepted bytes, wraps
module nibble_swap_arbiter
    import nibble_swap_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_swap,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [BYTE_W-1:0]         out_data,
    output logic [ID_W-1:0]           out_id,
    input  logic                      out_ready,
    output logic [CNT_W-1:0]          xfer_cnt
);

    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] grant;
    logic              slot_free;
    logic              accept;
    logic [BYTE_W-1:0] sel_data;
    logic              sel_swap;

    // rst_n gating keeps req_ready low during reset even though out_valid=0 frees the slot.
    assign slot_free = !out_valid || out_ready;
    assign accept    = rst_n && slot_free && (|req_valid);

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .en        (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;

    always_comb begin
        sel_data = '0;
        sel_swap = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_data = req_data[i*BYTE_W +: BYTE_W];
                sel_swap = req_swap[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            xfer_cnt  <= '0;
            rr_ptr    <= '0;
        end else if (accept) begin
            out_data  <= swap_nibbles(sel_data, sel_swap);
            out_id    <= grant_idx;
            out_valid <= 1'b1;
            xfer_cnt  <= xfer_cnt + CNT_W'(1);
            rr_ptr    <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
